// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the E-stage branch resolver: instruction kinds,
// branch condition codes and the redirect FSM state type.
package branch_resolve_pkg;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JAL    = 2'b10;
    localparam logic [1:0] KIND_JALR   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_SHADOW   = 2'b10
    } state_t;

endpackage

// File: rtl/branch_resolve_if.sv
// E-stage instruction bundle in, redirect/squash/link results out.
// master drives the E-stage slot, slave is the resolver.
interface branch_resolve_if;
    logic        e_valid;
    logic [1:0]  e_kind;
    logic [2:0]  e_funct3;
    logic [31:0] e_pc;
    logic [31:0] e_imm;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        squash;
    logic        misalign;
    logic        link_valid;
    logic [31:0] link_data;

    modport master (
        output e_valid, e_kind, e_funct3, e_pc, e_imm, e_rs1, e_rs2,
        input  pc_sel, pc_target, squash, misalign, link_valid, link_data
    );

    modport slave (
        input  e_valid, e_kind, e_funct3, e_pc, e_imm, e_rs1, e_rs2,
        output pc_sel, pc_target, squash, misalign, link_valid, link_data
    );
endinterface

// File: rtl/branch_resolve_cmp.sv
// Branch condition evaluator: purely combinational, zero latency, no backpressure.
// Reserved condition codes 010/011 never take.
module branch_cmp
    import branch_resolve_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// E-stage branch/jump resolver: one-cycle registered redirect, then SHADOW squash slots; no backpressure.
// Optional counters stat_resolved/stat_taken are built only when BRANCH_STATS_EN is defined.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h01000000,
    parameter int unsigned SHADOW   = 2
) (
    input  logic            clock,
    input  logic            reset,
    branch_resolve_if.slave br
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_taken
`endif
);

    localparam logic [2:0] SHADOW_CNT = 3'(SHADOW);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic        misalign_q, misalign_d;
    logic        link_valid_q, link_valid_d;
    logic [31:0] link_data_q, link_data_d;

    logic        cmp_taken;
    logic        accept;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
    logic        redirect;

    branch_cmp u_cmp (
        .funct3 (br.e_funct3),
        .rs1    (br.e_rs1),
        .rs2    (br.e_rs2),
        .taken  (cmp_taken)
    );

    // The E slot is only looked at while no redirect/shadow is in flight.
    assign accept  = (state_q == ST_IDLE) && br.e_valid && (br.e_kind != KIND_NONE);
    assign is_jump = (br.e_kind == KIND_JAL) || (br.e_kind == KIND_JALR);
    assign taken   = is_jump || ((br.e_kind == KIND_BRANCH) && cmp_taken);
    assign target  = (br.e_kind == KIND_JALR) ? ((br.e_rs1 + br.e_imm) & 32'hFFFF_FFFE)
                                              : (br.e_pc + br.e_imm);
    assign redirect = accept && taken && (target[1:0] == 2'b00);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        misalign_d   = 1'b0;
        link_valid_d = 1'b0;
        link_data_d  = link_data_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    state_d  = ST_REDIRECT;
                    target_d = target;
                    if (is_jump) begin
                        link_valid_d = 1'b1;
                        link_data_d  = br.e_pc + 32'd4;
                    end
                end else if (accept && taken) begin
                    misalign_d = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (SHADOW_CNT != 3'd0) begin
                    state_d = ST_SHADOW;
                    cnt_d   = SHADOW_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHADOW: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            target_q     <= RESET_PC;
            misalign_q   <= 1'b0;
            link_valid_q <= 1'b0;
            link_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            misalign_q   <= misalign_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
        end
    end

    assign br.pc_sel     = (state_q == ST_REDIRECT);
    assign br.squash     = (state_q != ST_IDLE);
    assign br.pc_target  = target_q;
    assign br.misalign   = misalign_q;
    assign br.link_valid = link_valid_q;
    assign br.link_data  = link_data_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] resolved_q, resolved_d;
    logic [31:0] taken_q, taken_d;

    always_comb begin
        resolved_d = resolved_q;
        taken_d    = taken_q;
        if (accept && (resolved_q != 32'hFFFF_FFFF)) begin
            resolved_d = resolved_q + 32'd1;
        end
        if (redirect && (taken_q != 32'hFFFF_FFFF)) begin
            taken_d = taken_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resolved_q <= 32'd0;
            taken_q    <= 32'd0;
        end else begin
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
        end
    end

    assign stat_resolved = resolved_q;
    assign stat_taken    = taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand-written multi-cycle sequences,
// and random traffic against a slot-counting reference model (SHADOW=2 and SHADOW=0 instances).
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam logic [31:0] RST_PC = 32'h01000000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    branch_resolve_if bif ();
    branch_resolve_if bif0 ();

    branch_resolve #(.RESET_PC(RST_PC), .SHADOW(2)) u_dut (
        .clock (clock),
        .reset (reset),
        .br    (bif.slave)
    );

    branch_resolve #(.RESET_PC(RST_PC), .SHADOW(0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .br    (bif0.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: remaining squashed slots plus the expected registered outputs.
    int          m_busy   [2];
    int          m_sh     [2];
    logic        m_pc_sel [2];
    logic [31:0] m_tgt    [2];
    logic        m_mis    [2];
    logic        m_lv     [2];
    logic [31:0] m_ld     [2];

    typedef struct {
        string       nm;
        logic        v;
        logic [1:0]  k;
        logic [2:0]  f3;
        logic [31:0] pc, imm, a, b;
        logic        sel;
        logic [31:0] tgt;
        logic        mis, lv;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
        bif.e_valid  = v;  bif0.e_valid  = v;
        bif.e_kind   = k;  bif0.e_kind   = k;
        bif.e_funct3 = f3; bif0.e_funct3 = f3;
        bif.e_pc     = pc; bif0.e_pc     = pc;
        bif.e_imm    = imm; bif0.e_imm   = imm;
        bif.e_rs1    = a;  bif0.e_rs1    = a;
        bif.e_rs2    = b;  bif0.e_rs2    = b;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] t;
        bit          tk;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] = 0; m_pc_sel[i] = 1'b0; m_tgt[i] = RST_PC;
                m_mis[i] = 1'b0; m_lv[i] = 1'b0; m_ld[i] = 32'd0;
            end else begin
                m_pc_sel[i] = 1'b0; m_mis[i] = 1'b0; m_lv[i] = 1'b0;
                if (m_busy[i] > 0) begin
                    m_busy[i]--;
                end else if (bif.e_valid && bif.e_kind != 2'b00) begin
                    if (bif.e_kind == 2'b11) t = (bif.e_rs1 + bif.e_imm) & 32'hFFFFFFFE;
                    else                     t = bif.e_pc + bif.e_imm;
                    tk = (bif.e_kind != 2'b01) || ref_taken(bif.e_funct3, bif.e_rs1, bif.e_rs2);
                    if (tk) begin
                        if (t % 4 != 0) begin
                            m_mis[i] = 1'b1;
                        end else begin
                            m_pc_sel[i] = 1'b1;
                            m_tgt[i]    = t;
                            m_busy[i]   = 1 + m_sh[i];
                            if (bif.e_kind != 2'b01) begin
                                m_lv[i] = 1'b1;
                                m_ld[i] = bif.e_pc + 32'd4;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp_model(input int i);
        logic ps, sq, mi, lv;
        logic [31:0] tg, ld;
        if (i == 0) begin
            ps = bif.pc_sel; sq = bif.squash; mi = bif.misalign; lv = bif.link_valid;
            tg = bif.pc_target; ld = bif.link_data;
        end else begin
            ps = bif0.pc_sel; sq = bif0.squash; mi = bif0.misalign; lv = bif0.link_valid;
            tg = bif0.pc_target; ld = bif0.link_data;
        end
        chk($sformatf("rnd%0d_pc_sel", i),    32'(ps), 32'(m_pc_sel[i]));
        chk($sformatf("rnd%0d_squash", i),    32'(sq), 32'(m_busy[i] > 0));
        chk($sformatf("rnd%0d_misalign", i),  32'(mi), 32'(m_mis[i]));
        chk($sformatf("rnd%0d_link_valid", i), 32'(lv), 32'(m_lv[i]));
        chk($sformatf("rnd%0d_pc_target", i), tg, m_tgt[i]);
        chk($sformatf("rnd%0d_link_data", i), ld, m_ld[i]);
    endtask

    function automatic vec_t mk(input string nm, input logic v, input logic [1:0] k, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                                input logic [31:0] b, input logic sel, input logic [31:0] tgt,
                                input logic mis, input logic lv, input logic [31:0] ld);
        vec_t r;
        r.nm = nm; r.v = v; r.k = k; r.f3 = f3; r.pc = pc; r.imm = imm; r.a = a; r.b = b;
        r.sel = sel; r.tgt = tgt; r.mis = mis; r.lv = lv; r.ld = ld;
        return r;
    endfunction

    initial begin
        m_sh[0] = 2; m_sh[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_pc_sel[i] = 0; m_tgt[i] = RST_PC; m_mis[i] = 0; m_lv[i] = 0; m_ld[i] = 0;
        end

        vecs[0]  = mk("beq_taken",   1, 2'b01, 3'b000, 32'h01000010, 32'h20, 32'd5, 32'd5, 1, 32'h01000030, 0, 0, 0);
        vecs[1]  = mk("bltu_not",    1, 2'b01, 3'b110, 32'h01000010, 32'h20, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0);
        vecs[2]  = mk("blt_taken",   1, 2'b01, 3'b100, 32'h01000100, 32'h10, 32'hFFFFFFFF, 32'd1, 1, 32'h01000110, 0, 0, 0);
        vecs[3]  = mk("jalr_misal",  1, 2'b11, 3'b000, 32'h01000040, 32'h2, 32'h01000101, 32'd0, 0, 0, 1, 0, 0);
        vecs[4]  = mk("jal_link",    1, 2'b10, 3'b000, 32'h01000000, 32'h8, 32'd0, 32'd0, 1, 32'h01000008, 0, 1, 32'h01000004);
        vecs[5]  = mk("bne_back",    1, 2'b01, 3'b001, 32'h01000200, 32'hFFFFFFF8, 32'd3, 32'd4, 1, 32'h010001F8, 0, 0, 0);
        vecs[6]  = mk("bge_not",     1, 2'b01, 3'b101, 32'h01000010, 32'h20, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0);
        vecs[7]  = mk("bgeu_taken",  1, 2'b01, 3'b111, 32'h00000010, 32'h100, 32'hFFFFFFFF, 32'd1, 1, 32'h00000110, 0, 0, 0);
        vecs[8]  = mk("f3_010",      1, 2'b01, 3'b010, 32'h01000010, 32'h20, 32'd7, 32'd7, 0, 0, 0, 0, 0);
        vecs[9]  = mk("f3_011",      1, 2'b01, 3'b011, 32'h01000010, 32'h20, 32'd1, 32'd2, 0, 0, 0, 0, 0);
        vecs[10] = mk("kind_none",   1, 2'b00, 3'b000, 32'h01000010, 32'h20, 32'd5, 32'd5, 0, 0, 0, 0, 0);
        vecs[11] = mk("beq_misal",   1, 2'b01, 3'b000, 32'h01000010, 32'h6, 32'd5, 32'd5, 0, 0, 1, 0, 0);
        vecs[12] = mk("jalr_align",  1, 2'b11, 3'b000, 32'h00000100, 32'h3, 32'h00002001, 32'd0, 1, 32'h00002004, 0, 1, 32'h00000104);
        vecs[13] = mk("bne_equal",   1, 2'b01, 3'b001, 32'h01000010, 32'h20, 32'd9, 32'd9, 0, 0, 0, 0, 0);
        vecs[14] = mk("beq_wrap",    1, 2'b01, 3'b000, 32'hFFFFFFF0, 32'h20, 32'd1, 32'd1, 1, 32'h00000010, 0, 0, 0);
        vecs[15] = mk("jal_invalid", 0, 2'b10, 3'b000, 32'h01000000, 32'h8, 32'd0, 32'd0, 0, 0, 0, 0, 0);

        reset = 1'b1;
        idle_in();
        tick();
        tick();
        chk("rst_pc_sel",     32'(bif.pc_sel), 32'd0);
        chk("rst_squash",     32'(bif.squash), 32'd0);
        chk("rst_misalign",   32'(bif.misalign), 32'd0);
        chk("rst_link_valid", 32'(bif.link_valid), 32'd0);
        chk("rst_link_data",  bif.link_data, 32'd0);
        chk("rst_pc_target",  bif.pc_target, RST_PC);
        chk("rst0_pc_target", bif0.pc_target, RST_PC);
        reset = 1'b0;
        tick();

        foreach (vecs[n]) begin
            drive(vecs[n].v, vecs[n].k, vecs[n].f3, vecs[n].pc, vecs[n].imm, vecs[n].a, vecs[n].b);
            tick();
            idle_in();
            chk({vecs[n].nm, "_pc_sel"},     32'(bif.pc_sel), 32'(vecs[n].sel));
            chk({vecs[n].nm, "_misalign"},   32'(bif.misalign), 32'(vecs[n].mis));
            chk({vecs[n].nm, "_link_valid"}, 32'(bif.link_valid), 32'(vecs[n].lv));
            chk({vecs[n].nm, "_squash"},     32'(bif.squash), 32'(vecs[n].sel));
            if (vecs[n].sel) chk({vecs[n].nm, "_pc_target"}, bif.pc_target, vecs[n].tgt);
            if (vecs[n].lv)  chk({vecs[n].nm, "_link_data"}, bif.link_data, vecs[n].ld);
            tick();
            chk({vecs[n].nm, "_pulse_done"}, 32'({bif.pc_sel, bif.misalign, bif.link_valid}), 32'd0);
            for (int c = 0; c < 3; c++) tick();
        end

        // Squash window length: 3 slots with SHADOW=2, 1 slot with SHADOW=0.
        drive(1, 2'b01, 3'b000, 32'h01000010, 32'h20, 32'd5, 32'd5);
        tick();
        idle_in();
        chk("sq_c0_pc_sel", 32'(bif.pc_sel), 32'd1);
        chk("sq_c0_target", bif.pc_target, 32'h01000030);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("sq_c%0d_squash", c - 1), 32'(bif.squash), 32'(c <= 3));
            chk($sformatf("sq0_c%0d_squash", c - 1), 32'(bif0.squash), 32'(c == 1));
            tick();
            chk($sformatf("sq_c%0d_pc_sel", c), 32'(bif.pc_sel), 32'd0);
        end
        chk("sq_c3_squash", 32'(bif.squash), 32'd0);
        tick();

        // jal, then taken beq for two cycles: ignored with SHADOW=2; with SHADOW=0 the second is taken.
        drive(1, 2'b10, 3'b000, 32'h01000000, 32'h8, 32'd0, 32'd0);
        tick();
        chk("jal_pc_sel",     32'(bif.pc_sel), 32'd1);
        chk("jal_target",     bif.pc_target, 32'h01000008);
        chk("jal_link_valid", 32'(bif.link_valid), 32'd1);
        chk("jal_link_data",  bif.link_data, 32'h01000004);
        drive(1, 2'b01, 3'b000, 32'h01000500, 32'h40, 32'd1, 32'd1);
        tick();
        chk("jal_beq1_pc_sel",  32'(bif.pc_sel), 32'd0);
        chk("jal_beq1_link",    32'(bif.link_valid), 32'd0);
        chk("s0_beq1_pc_sel",   32'(bif0.pc_sel), 32'd0);
        tick();
        idle_in();
        chk("jal_beq2_pc_sel",  32'(bif.pc_sel), 32'd0);
        chk("jal_beq2_target",  bif.pc_target, 32'h01000008);
        chk("s0_beq2_pc_sel",   32'(bif0.pc_sel), 32'd1);
        chk("s0_beq2_target",   bif0.pc_target, 32'h01000540);
        chk("jal_link_hold",    bif.link_data, 32'h01000004);
        for (int c = 0; c < 4; c++) tick();
        chk("jal_no_late_redirect", 32'(bif.pc_sel), 32'd0);

        // Reset landing on the REDIRECT cycle.
        drive(1, 2'b01, 3'b000, 32'h01000010, 32'h20, 32'd5, 32'd5);
        tick();
        idle_in();
        chk("rr_in_redirect", 32'(bif.pc_sel), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rr_pc_sel",    32'(bif.pc_sel), 32'd0);
        chk("rr_squash",    32'(bif.squash), 32'd0);
        chk("rr_pc_target", bif.pc_target, RST_PC);
        drive(1, 2'b01, 3'b001, 32'h01000080, 32'h100, 32'd1, 32'd2);
        tick();
        idle_in();
        chk("rr_next_pc_sel", 32'(bif.pc_sel), 32'd1);
        chk("rr_next_target", bif.pc_target, 32'h01000180);
        for (int c = 0; c < 4; c++) tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] ops [4];
            logic [31:0] imm;
            ops[0] = 32'd5; ops[1] = 32'hFFFFFFFF; ops[2] = $urandom; ops[3] = 32'h80000000;
            imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : ($urandom & 32'h0000_0FFC);
            reset = ($urandom_range(0, 60) == 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
                  $urandom & 32'hFFFF_FFFC, imm,
                  ops[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), ops[$urandom_range(0, 3)]);
            tick();
            cmp_model(0);
            cmp_model(1);
        end
        reset = 1'b0;
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
